assoc_read_cache: RTL and testbench



---
 rtl/assoc_cache_pkg.sv | 23 ++
 rtl/cache_way.sv | 55 +++++
 rtl/assoc_read_cache.sv | 160 ++++++++++++++++
 tb/tb_assoc_read_cache.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared types and address-split width helpers for the 2-way read-only cache.
package assoc_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        FILL,
        RESPOND
    } state_t;

    function automatic int off_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int block_words, input int sets);
        return addr_w - $clog2(block_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid bits in flops (bulk-clearable), tag and data in RAM arrays.
// Reads are registered and hold their value while rd_en is low.
module cache_way #(
    parameter int TAG_W   = 6,
    parameter int IDX_W   = 7,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_block,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_block
);
    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]    valid_reg;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [BLOCK_W-1:0] data_mem [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (clr) begin
                valid_reg <= '0;
            end else if (wr_en) begin
                valid_reg[wr_idx] <= 1'b1;
            end
            if (rd_en) begin
                rd_valid <= valid_reg[rd_idx];
            end
        end
    end

    // Tag/data storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_block;
        end
        if (rd_en) begin
            rd_tag   <= tag_mem[rd_idx];
            rd_block <= data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/assoc_read_cache.sv
// 2-way set-associative read-only cache with true-LRU replacement, bulk invalidate,
// saturating hit/miss counters and a block-wide main-memory fill handshake.
module assoc_read_cache
    import assoc_cache_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 128,
    parameter int CNT_W       = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cpu_req,
    input  logic [ADDR_W-1:0]                         cpu_addr,
    input  logic                                      inv,
    output logic [WORD_W-1:0]                         cpu_data,
    output logic                                      cpu_ready,
    output logic                                      hit,
    output logic                                      mm_req,
    output logic [ADDR_W-off_w(BLOCK_WORDS)-1:0]      mm_addr,
    input  logic                                      mm_ready,
    input  logic [BLOCK_WORDS*WORD_W-1:0]             mm_block,
    output logic [CNT_W-1:0]                          hit_count,
    output logic [CNT_W-1:0]                          miss_count
);
    localparam int OFF_W   = off_w(BLOCK_WORDS);
    localparam int IDX_W   = idx_w(SETS);
    localparam int TAG_W   = tag_w(ADDR_W, BLOCK_WORDS, SETS);
    localparam int BLOCK_W = BLOCK_WORDS * WORD_W;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [SETS-1:0]     lru_reg;
    logic [WORD_W-1:0]   fill_word_reg;

    logic [OFF_W-1:0]    off_sel;
    logic [IDX_W-1:0]    idx_sel;
    logic [TAG_W-1:0]    tag_sel;
    logic [1:0]          way_valid, way_hit, way_wr;
    logic [TAG_W-1:0]    way_tag   [2];
    logic [BLOCK_W-1:0]  way_block [2];
    logic [BLOCK_W-1:0]  hit_block;
    logic [WORD_W-1:0]   hit_words  [BLOCK_WORDS];
    logic [WORD_W-1:0]   fill_words [BLOCK_WORDS];
    logic                hit_way, any_hit, victim;
    logic                accept;

    assign off_sel = addr_reg[OFF_W-1:0];
    assign idx_sel = addr_reg[OFF_W +: IDX_W];
    assign tag_sel = addr_reg[ADDR_W-1 -: TAG_W];
    assign accept  = (state_reg == IDLE) && !inv && cpu_req;

    // The ways are read with the live CPU address while idle, so tags are ready in COMPARE.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            cache_way #(
                .TAG_W  (TAG_W),
                .IDX_W  (IDX_W),
                .BLOCK_W(BLOCK_W)
            ) u_way (
                .clk     (clk),
                .rst     (rst),
                .clr     ((state_reg == IDLE) && inv),
                .rd_en   (state_reg == IDLE),
                .rd_idx  (cpu_addr[OFF_W +: IDX_W]),
                .rd_valid(way_valid[gi]),
                .rd_tag  (way_tag[gi]),
                .rd_block(way_block[gi]),
                .wr_en   (way_wr[gi]),
                .wr_idx  (idx_sel),
                .wr_tag  (tag_sel),
                .wr_block(mm_block)
            );
            assign way_hit[gi] = way_valid[gi] && (way_tag[gi] == tag_sel);
            assign way_wr[gi]  = (state_reg == FILL) && mm_ready && (victim == 1'(gi));
        end

        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
            assign hit_words[gi]  = hit_block[gi*WORD_W +: WORD_W];
            assign fill_words[gi] = mm_block[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign any_hit   = |way_hit;
    assign hit_way   = way_hit[1];
    assign hit_block = way_block[hit_way];

    // Empty ways fill first (way 0 before way 1); otherwise evict the LRU way.
    always_comb begin
        victim = lru_reg[idx_sel];
        if (!way_valid[0]) begin
            victim = 1'b0;
        end else if (!way_valid[1]) begin
            victim = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cpu_ready  = 1'b0;
        hit        = 1'b0;
        cpu_data   = '0;
        mm_req     = 1'b0;
        mm_addr    = '0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = COMPARE;
            end
            COMPARE: begin
                if (any_hit) begin
                    cpu_ready  = 1'b1;
                    hit        = 1'b1;
                    cpu_data   = hit_words[off_sel];
                    state_next = IDLE;
                end else begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mm_req  = 1'b1;
                mm_addr = addr_reg[ADDR_W-1:OFF_W];
                if (mm_ready) state_next = RESPOND;
            end
            RESPOND: begin
                cpu_ready  = 1'b1;
                cpu_data   = fill_word_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            lru_reg       <= '0;
            fill_word_reg <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) addr_reg <= cpu_addr;
            if ((state_reg == IDLE) && inv) lru_reg <= '0;
            if ((state_reg == COMPARE) && any_hit) begin
                lru_reg[idx_sel] <= ~hit_way;
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end
            if ((state_reg == COMPARE) && !any_hit) begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
            if ((state_reg == FILL) && mm_ready) begin
                lru_reg[idx_sel] <= ~victim;
                fill_word_reg    <= fill_words[off_sel];
            end
        end
    end

endmodule

// File: tb/tb_assoc_read_cache.sv
// Directed bench for assoc_read_cache: per-cycle output compare against an LRU-list
// cache model and a functional memory image, plus hand-computed literal checks.
module tb_assoc_read_cache;
    localparam int ADDR_W = 15;
    localparam int WORD_W = 32;
    localparam int BW     = 4;
    localparam int SETS   = 128;
    localparam int CNT_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst, cpu_req, inv, mm_ready;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [WORD_W-1:0]    cpu_data;
    logic                 cpu_ready, hit, mm_req;
    logic [ADDR_W-3:0]    mm_addr;
    logic [BW*WORD_W-1:0] mm_block;
    logic [CNT_W-1:0]     hit_count, miss_count;

    assoc_read_cache #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW), .SETS(SETS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .inv(inv),
        .cpu_data(cpu_data), .cpu_ready(cpu_ready), .hit(hit), .mm_req(mm_req),
        .mm_addr(mm_addr), .mm_ready(mm_ready), .mm_block(mm_block),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle, maintained by the stimulus thread.
    bit             chk_en = 1'b0;
    logic           exp_ready = 1'b0, exp_hit = 1'b0, exp_mm_req = 1'b0;
    logic [31:0]    exp_data = '0;
    logic [12:0]    exp_mm_addr = '0;
    logic [1:0]     exp_hc = '0, exp_mc = '0;

    // Model: per set, a recency-ordered list of resident tags (index 0 = MRU).
    int tag_q [SETS][2];
    int n_valid [SETS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input int blk, input int off);
        if (blk == 1) return 32'(off * 32'h11);
        return 32'hA000_0000 | 32'(blk << 4) | 32'(off);
    endfunction

    function automatic logic [BW*WORD_W-1:0] mk_block(input int blk);
        logic [BW*WORD_W-1:0] b;
        for (int i = 0; i < BW; i++) b[i*WORD_W +: WORD_W] = mem_word(blk, i);
        return b;
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic bit model_hit(input int blk);
        int s = blk % SETS;
        for (int i = 0; i < n_valid[s]; i++) if (tag_q[s][i] == blk / SETS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_use(input int blk);
        int s = blk % SETS;
        int t = blk / SETS;
        if (n_valid[s] > 0 && tag_q[s][0] == t) return;
        tag_q[s][1] = tag_q[s][0];
        tag_q[s][0] = t;
        if (n_valid[s] < 2) n_valid[s]++;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) n_valid[s] = 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
            chk("hit", 32'(hit), 32'(exp_hit));
            chk("cpu_data", cpu_data, exp_data);
            chk("mm_req", 32'(mm_req), 32'(exp_mm_req));
            chk("mm_addr", 32'(mm_addr), 32'(exp_mm_addr));
            chk("hit_count", 32'(hit_count), 32'(exp_hc));
            chk("miss_count", 32'(miss_count), 32'(exp_mc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CPU read; fill_wait = FILL cycles before the mm_ready cycle.
    task automatic do_read(input int addr, input int fill_wait, output logic got_hit,
                           output logic [31:0] got_data, output int lat, output logic [12:0] got_mma);
        int blk = addr >> 2;
        int off = addr & 3;
        bit h = model_hit(blk);
        got_mma = '0;
        cpu_req = 1'b1;
        cpu_addr = ADDR_W'(addr);
        step();
        cpu_req = 1'b0;
        lat = 1;
        if (h) begin
            exp_ready = 1'b1; exp_hit = 1'b1; exp_data = mem_word(blk, off);
            got_hit = hit; got_data = cpu_data;
            step();
            exp_hc = sat_inc(exp_hc);
        end else begin
            step();
            lat++;
            exp_mc = sat_inc(exp_mc);
            exp_mm_req = 1'b1; exp_mm_addr = 13'(blk);
            got_mma = mm_addr;
            repeat (fill_wait) begin
                step();
                lat++;
            end
            mm_ready = 1'b1;
            mm_block = mk_block(blk);
            step();
            lat++;
            mm_ready = 1'b0;
            exp_mm_req = 1'b0; exp_mm_addr = '0;
            exp_ready = 1'b1; exp_hit = 1'b0; exp_data = mem_word(blk, off);
            got_hit = hit; got_data = cpu_data;
            step();
        end
        exp_ready = 1'b0; exp_hit = 1'b0; exp_data = '0;
        model_use(blk);
        $display("read addr=%h hit=%0b data=%h latency=%0d", addr[14:0], got_hit, got_data, lat);
    endtask

    logic        r_hit;
    logic [31:0] r_data;
    int          r_lat;
    logic [12:0] r_mma;

    initial begin
        rst = 1'b1; cpu_req = 1'b0; inv = 1'b0; mm_ready = 1'b0;
        cpu_addr = '0; mm_block = '0;
        model_clear();
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Cold miss: block 1 holds 0x00,0x11,0x22,0x33; mm_ready after 3 wait cycles.
        do_read(15'h0006, 3, r_hit, r_data, r_lat, r_mma);
        chk("cold_data", r_data, 32'h22);
        chk("cold_hit", 32'(r_hit), 32'd0);
        chk("cold_mm_addr", 32'(r_mma), 32'h1);
        chk("cold_latency", 32'(r_lat), 32'd6);
        chk("cold_miss_count", 32'(miss_count), 32'd1);

        // Hit in the same block.
        do_read(15'h0004, 0, r_hit, r_data, r_lat, r_mma);
        chk("hit_data", r_data, 32'h00);
        chk("hit_flag", 32'(r_hit), 32'd1);
        chk("hit_latency", 32'(r_lat), 32'd1);
        chk("hit_count_1", 32'(hit_count), 32'd1);

        // LRU: tags 0,1 at index 0, touch tag 0, then tag 2 evicts tag 1.
        do_read(15'h0000, 1, r_hit, r_data, r_lat, r_mma);
        do_read(15'h0200, 2, r_hit, r_data, r_lat, r_mma);
        chk("fill_tag1_mm_addr", 32'(r_mma), 32'h80);
        do_read(15'h0000, 0, r_hit, r_data, r_lat, r_mma);
        chk("touch_tag0_hit", 32'(r_hit), 32'd1);
        do_read(15'h0401, 0, r_hit, r_data, r_lat, r_mma);
        chk("tag2_miss", 32'(r_hit), 32'd0);
        chk("tag2_data", r_data, 32'hA000_1001);
        do_read(15'h0003, 0, r_hit, r_data, r_lat, r_mma);
        chk("tag0_survives", 32'(r_hit), 32'd1);
        chk("tag0_data", r_data, 32'hA000_0003);
        do_read(15'h0200, 0, r_hit, r_data, r_lat, r_mma);
        chk("tag1_evicted", 32'(r_hit), 32'd0);

        // Invalidate together with a request: the request is dropped.
        inv = 1'b1; cpu_req = 1'b1; cpu_addr = '0;
        step();
        inv = 1'b0; cpu_req = 1'b0;
        model_clear();
        step();
        do_read(15'h0000, 0, r_hit, r_data, r_lat, r_mma);
        chk("inv_then_miss", 32'(r_hit), 32'd0);
        chk("inv_mm_addr", 32'(r_mma), 32'h0);

        // Reset while a fill is outstanding, then a stale mm_ready.
        cpu_req = 1'b1; cpu_addr = 15'h0008;
        step();
        cpu_req = 1'b0;
        step();
        exp_mc = sat_inc(exp_mc); exp_mm_req = 1'b1; exp_mm_addr = 13'h2;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_mm_req = 1'b0; exp_mm_addr = '0; exp_hc = '0; exp_mc = '0;
        model_clear();
        mm_ready = 1'b1; mm_block = mk_block(2);
        step();
        mm_ready = 1'b0;
        step();
        chk("rst_fill_mm_req", 32'(mm_req), 32'd0);
        chk("rst_fill_ready", 32'(cpu_ready), 32'd0);
        chk("rst_fill_counts", 32'({hit_count, miss_count}), 32'd0);
        do_read(15'h0008, 0, r_hit, r_data, r_lat, r_mma);
        chk("rst_fill_then_miss", 32'(r_hit), 32'd0);

        // Saturation: five hits leave the 2-bit hit counter at 3.
        for (int i = 0; i < 5; i++) do_read(15'h0008 + 15'(i % 4), 0, r_hit, r_data, r_lat, r_mma);
        chk("hit_sat", 32'(hit_count), 32'd3);
        chk("miss_after_sat", 32'(miss_count), 32'd1);

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
